// File: rtl/pb_filter_bank.sv
// pb_filter_bank: N-channel push-button front end.
// Synchronises raw button pins, debounces each channel, optionally enforces a
// one-button-at-a-time lockout, and emits press / release / long-press pulses.
//
// Ports:
//   clk            system clock
//   rst            synchronous, active-high reset
//   pb_raw         asynchronous raw button pins (polarity set by ACTIVE_LOW)
//   pb_fltrd_n     filtered level, active-low (0 = pressed)
//   pressed        filtered level, active-high
//   press_pulse    1-cycle pulse on an accepted press
//   release_pulse  1-cycle pulse on an accepted release
//   long_pulse     1-cycle pulse once a press has been held for LONG_CYCLES
module pb_filter_bank #(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned LONG_CYCLES     = 50000000,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter bit          EXCLUSIVE       = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] pb_raw,
  output logic [CHANNELS-1:0] pb_fltrd_n,
  output logic [CHANNELS-1:0] pressed,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] long_pulse
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned LW = $clog2(LONG_CYCLES + 1);

  localparam logic [DW-1:0]       DebLast  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0]       LongLast = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0]       LongMax  = LW'(LONG_CYCLES);
  // Raw pin level of a released button.
  localparam logic [CHANNELS-1:0] Released = {CHANNELS{ACTIVE_LOW}};

  logic [CHANNELS-1:0] sync1_q, sync2_q;
  logic [CHANNELS-1:0] pressed_q, pressed_d;
  logic [CHANNELS-1:0] press_q, press_d;
  logic [CHANNELS-1:0] release_q, release_d;
  logic [CHANNELS-1:0] long_q, long_d;
  logic [CHANNELS-1:0] lockout_q, lockout_d;
  logic [DW-1:0]       dcnt_q [CHANNELS];
  logic [DW-1:0]       dcnt_d [CHANNELS];
  logic [LW-1:0]       lcnt_q [CHANNELS];
  logic [LW-1:0]       lcnt_d [CHANNELS];

  logic [CHANNELS-1:0] s;
  logic                taken;

  always_comb begin
    s         = sync2_q ^ Released;
    pressed_d = pressed_q;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    lockout_d = lockout_q;
    // Eligibility uses the registered levels only, so a release elsewhere on
    // this edge does not free the slot. Granting a press also blocks any
    // higher-index channel on the same edge (lowest index wins).
    taken     = |pressed_q;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      dcnt_d[i] = '0;
      if (lockout_q[i]) begin
        if (!s[i]) lockout_d[i] = 1'b0;
      end else if (s[i] != pressed_q[i]) begin
        if (dcnt_q[i] == DebLast) begin
          if (pressed_q[i]) begin
            pressed_d[i] = 1'b0;
            release_d[i] = 1'b1;
          end else if (!EXCLUSIVE || !taken) begin
            pressed_d[i] = 1'b1;
            press_d[i]   = 1'b1;
            taken        = 1'b1;
          end else begin
            lockout_d[i] = 1'b1;
          end
        end else begin
          dcnt_d[i] = dcnt_q[i] + 1'b1;
        end
      end

      // Only counts while held across the edge, so the press edge itself can
      // never see a long pulse and a release clears the count immediately.
      lcnt_d[i] = '0;
      if (pressed_q[i] && pressed_d[i]) begin
        lcnt_d[i] = (lcnt_q[i] == LongMax) ? lcnt_q[i] : lcnt_q[i] + 1'b1;
        long_d[i] = (lcnt_q[i] == LongLast);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= Released;
      sync2_q   <= Released;
      pressed_q <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      lockout_q <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        dcnt_q[i] <= '0;
        lcnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= pb_raw;
      sync2_q   <= sync1_q;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      lockout_q <= lockout_d;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        dcnt_q[i] <= dcnt_d[i];
        lcnt_q[i] <= lcnt_d[i];
      end
    end
  end

  assign pressed       = pressed_q;
  assign pb_fltrd_n    = ~pressed_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;

endmodule

// File: tb/tb_pb_filter_bank.sv
// Directed bench for pb_filter_bank: one exclusive and one independent instance
// share the same pins (CHANNELS=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=16, active-low).
module tb_pb_filter_bank;

  logic       clk;
  logic       rst;
  logic [3:0] pb_raw;

  logic [3:0] fltrd_a, pressed_a, press_a, rel_a, long_a;
  logic [3:0] fltrd_b, pressed_b, press_b, rel_b, long_b;

  int checks = 0;
  int errors = 0;
  int press_cnt_a, rel_cnt_a, long_cnt_a, press_cnt_b;

  pb_filter_bank #(
    .CHANNELS       (4),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (16),
    .ACTIVE_LOW     (1'b1),
    .EXCLUSIVE      (1'b1)
  ) dut_a (
    .clk          (clk),
    .rst          (rst),
    .pb_raw       (pb_raw),
    .pb_fltrd_n   (fltrd_a),
    .pressed      (pressed_a),
    .press_pulse  (press_a),
    .release_pulse(rel_a),
    .long_pulse   (long_a)
  );

  pb_filter_bank #(
    .CHANNELS       (4),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (16),
    .ACTIVE_LOW     (1'b1),
    .EXCLUSIVE      (1'b0)
  ) dut_b (
    .clk          (clk),
    .rst          (rst),
    .pb_raw       (pb_raw),
    .pb_fltrd_n   (fltrd_b),
    .pressed      (pressed_b),
    .press_pulse  (press_b),
    .release_pulse(rel_b),
    .long_pulse   (long_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] raw;
    int         cycles;
    logic [3:0] exp_pressed_a;
    int         exp_press_a;
    int         exp_rel_a;
    int         exp_long_a;
    logic [3:0] exp_pressed_b;
    int         exp_press_b;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    press_cnt_a = 0;
    rel_cnt_a   = 0;
    long_cnt_a  = 0;
    press_cnt_b = 0;
  endtask

  // One clock edge; outputs are then sampled and inputs may be changed.
  task automatic tick();
    @(posedge clk);
    #1;
    press_cnt_a += $countones(press_a);
    rel_cnt_a   += $countones(rel_a);
    long_cnt_a  += $countones(long_a);
    press_cnt_b += $countones(press_b);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // sel 0: any press pulse on either instance within mask; sel 1: long_a within mask.
  // Returns edges taken, or bound+1 on timeout.
  task automatic wait_for(input int sel, input logic [3:0] mask, input int bound, output int n);
    logic hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n <= bound) begin
      tick();
      n++;
      if (sel == 0) hit = |((press_a | press_b) & mask);
      else          hit = |(long_a & mask);
    end
  endtask

  int n;

  initial begin
    // Expected counts are totals over all channels during the row's hold.
    vecs[0] = '{4'b1011,  10, 4'b0100, 1, 0, 0, 4'b0100, 1};  // ch2 press
    vecs[1] = '{4'b0011,  10, 4'b0100, 0, 0, 0, 4'b1100, 1};  // ch3 locked out in A
    vecs[2] = '{4'b0111,  10, 4'b0000, 0, 1, 1, 4'b1000, 0};  // ch2 long then release
    vecs[3] = '{4'b1111,  10, 4'b0000, 0, 0, 0, 4'b0000, 0};  // lockout clears
    vecs[4] = '{4'b0111,  10, 4'b1000, 1, 0, 0, 4'b1000, 1};  // fresh ch3 press
    vecs[5] = '{4'b1111,  10, 4'b0000, 0, 1, 0, 4'b0000, 0};
    vecs[6] = '{4'b1110, 120, 4'b0001, 1, 0, 1, 4'b0001, 1};  // long hold, one long
    vecs[7] = '{4'b1111,  10, 4'b0000, 0, 1, 0, 4'b0000, 0};
    vecs[8] = '{4'b1110,  14, 4'b0001, 1, 0, 0, 4'b0001, 1};  // lcnt=8 at row end
    vecs[9] = '{4'b1111,  10, 4'b0000, 0, 1, 0, 4'b0000, 0};  // released at lcnt 13

    // Reset
    rst    = 1'b1;
    pb_raw = 4'hF;
    clear_counts();
    ticks(3);
    check("reset pressed_a", pressed_a, 4'h0);
    check("reset fltrd_a", fltrd_a, 4'hF);
    check("reset pulses_a", press_a | rel_a | long_a, 4'h0);
    check("reset pressed_b", pressed_b, 4'h0);
    check("reset fltrd_b", fltrd_b, 4'hF);
    check("reset pulses_b", press_b | rel_b | long_b, 4'h0);
    rst = 1'b0;
    ticks(2);

    // Basic press: stable before edge k, accepted at edge k+5 (6th edge).
    pb_raw = 4'b1110;
    wait_for(0, 4'b0001, 20, n);
    check("basic press latency", n, 6);
    check("basic press_pulse", press_a, 4'b0001);
    check("basic pressed", pressed_a, 4'b0001);
    check("basic fltrd", fltrd_a, 4'b1110);
    tick();
    check("basic press one cycle", press_a, 4'b0000);
    ticks(8);
    pb_raw = 4'hF;
    n = 0;
    while (rel_a[0] !== 1'b1 && n <= 20) begin
      tick();
      n++;
    end
    check("basic release latency", n, 6);
    check("basic release fltrd", fltrd_a, 4'hF);
    ticks(3);

    // Glitch rejection: 3 low, 1 high, repeated for 40 cycles.
    clear_counts();
    for (int g = 0; g < 10; g++) begin
      pb_raw = 4'b1101;
      ticks(3);
      pb_raw = 4'hF;
      tick();
    end
    check("glitch pressed", pressed_a | pressed_b, 4'h0);
    check("glitch pulses", press_cnt_a + rel_cnt_a + press_cnt_b, 0);
    ticks(6);

    // Table-driven lockout / long-press sequences.
    for (int v = 0; v < 10; v++) begin
      clear_counts();
      pb_raw = vecs[v].raw;
      ticks(vecs[v].cycles);
      check($sformatf("vec%0d pressed_a", v), pressed_a, vecs[v].exp_pressed_a);
      check($sformatf("vec%0d press_cnt_a", v), press_cnt_a, vecs[v].exp_press_a);
      check($sformatf("vec%0d rel_cnt_a", v), rel_cnt_a, vecs[v].exp_rel_a);
      check($sformatf("vec%0d long_cnt_a", v), long_cnt_a, vecs[v].exp_long_a);
      check($sformatf("vec%0d pressed_b", v), pressed_b, vecs[v].exp_pressed_b);
      check($sformatf("vec%0d press_cnt_b", v), press_cnt_b, vecs[v].exp_press_b);
    end

    // Simultaneous press on channels 1 and 3.
    pb_raw = 4'b0101;
    wait_for(0, 4'b1111, 20, n);
    check("simul latency", n, 6);
    check("simul press_a", press_a, 4'b0010);
    check("simul press_b", press_b, 4'b1010);
    ticks(10);
    check("simul pressed_a", pressed_a, 4'b0010);
    pb_raw = 4'hF;
    ticks(10);
    check("simul released", pressed_a | pressed_b, 4'h0);

    // Long press exactly 16 edges after press, once only over a 100-cycle hold.
    pb_raw = 4'b1110;
    wait_for(0, 4'b0001, 20, n);
    check("long press seen", n, 6);
    wait_for(1, 4'b0001, 40, n);
    check("long latency", n, 16);
    clear_counts();
    ticks(84);
    check("long only once", long_cnt_a, 0);
    pb_raw = 4'hF;
    ticks(10);

    // Reset mid-press with lcnt=8; button stays held.
    pb_raw = 4'b1110;
    wait_for(0, 4'b0001, 20, n);
    ticks(8);
    clear_counts();
    rst = 1'b1;
    tick();
    check("midrst pressed", pressed_a, 4'h0);
    check("midrst fltrd", fltrd_a, 4'hF);
    check("midrst no release", rel_a | rel_b, 4'h0);
    rst = 1'b0;
    // Sync flops restart from released level: 2 sync edges + 4 debounce edges.
    wait_for(0, 4'b0001, 20, n);
    check("midrst repress latency", n, 6);
    check("midrst release count", rel_cnt_a, 0);
    pb_raw = 4'hF;
    ticks(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
